// File: rtl/mem_master.sv
// Bus initiator for the 4096x12 main memory: READ, WRITE, ISZ-style INC and IND.
// Define MEM_AUTOINDEX_EN to enable PDP-8 auto-indexing of 12'o0010..12'o0017 on IND.
module mem_master (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [11:0] cmd_addr,
    input  logic [11:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [11:0] rsp_data,
    output logic [11:0] rsp_addr,
    output logic        rsp_skip,
    output logic        ram_oe,
    output logic        ram_we,
    output logic [11:0] ram_addr,
    output logic [11:0] ram_wdata,
    input  logic [11:0] ram_rdata
);
    localparam int unsigned W = 12;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_INC   = 2'd2;

    // S_CMD is the setup cycle between acceptance and the first memory access.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CMD    = 4'd1,
        S_RD     = 4'd2,
        S_WR     = 4'd3,
        S_INC_RD = 4'd4,
        S_INC_WR = 4'd5,
        S_PTR_RD = 4'd6,
`ifdef MEM_AUTOINDEX_EN
        S_AIX_WR = 4'd7,
`endif
        S_TGT_RD = 4'd8
    } state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [W-1:0] r_addr;
    logic [W-1:0] r_wdata;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [W-1:0] r_rsp_data;
    logic [W-1:0] r_rsp_addr;
    logic        r_rsp_skip;
    logic        r_ram_oe;
    logic        r_ram_we;
    logic [W-1:0] r_ram_addr;
    logic [W-1:0] r_ram_wdata;

    logic [W-1:0] w_inc;
    assign w_inc = W'(ram_rdata + 12'd1);

`ifdef MEM_AUTOINDEX_EN
    logic w_aix;
    assign w_aix = (r_addr[11:3] == 9'd1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_addr  <= '0;
            r_rsp_skip  <= 1'b0;
            r_ram_oe    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cmd_op;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_CMD;
                    end
                end
                S_CMD: begin
                    r_ram_addr <= r_addr;
                    case (r_op)
                        OP_READ: begin
                            r_ram_oe <= 1'b1;
                            r_state  <= S_RD;
                        end
                        OP_WRITE: begin
                            r_ram_we    <= 1'b1;
                            r_ram_wdata <= r_wdata;
                            r_state     <= S_WR;
                        end
                        OP_INC: begin
                            r_ram_oe <= 1'b1;
                            r_state  <= S_INC_RD;
                        end
                        default: begin
                            r_ram_oe <= 1'b1;
                            r_state  <= S_PTR_RD;
                        end
                    endcase
                end
                S_RD, S_TGT_RD: begin
                    r_ram_oe    <= 1'b0;
                    r_rsp_data  <= ram_rdata;
                    r_rsp_addr  <= r_ram_addr;
                    r_rsp_skip  <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_WR: begin
                    r_ram_we    <= 1'b0;
                    r_rsp_data  <= r_ram_wdata;
                    r_rsp_addr  <= r_ram_addr;
                    r_rsp_skip  <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_INC_RD: begin
                    r_ram_oe    <= 1'b0;
                    r_ram_we    <= 1'b1;
                    r_ram_wdata <= w_inc;
                    r_state     <= S_INC_WR;
                end
                S_INC_WR: begin
                    r_ram_we    <= 1'b0;
                    r_rsp_data  <= r_ram_wdata;
                    r_rsp_addr  <= r_ram_addr;
                    r_rsp_skip  <= (r_ram_wdata == '0);
                    r_rsp_valid <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_PTR_RD: begin
`ifdef MEM_AUTOINDEX_EN
                    if (w_aix) begin
                        // Write the bumped pointer back to the same location first.
                        r_ram_oe    <= 1'b0;
                        r_ram_we    <= 1'b1;
                        r_ram_wdata <= w_inc;
                        r_state     <= S_AIX_WR;
                    end else begin
                        r_ram_addr <= ram_rdata;
                        r_state    <= S_TGT_RD;
                    end
`else
                    r_ram_addr <= ram_rdata;
                    r_state    <= S_TGT_RD;
`endif
                end
`ifdef MEM_AUTOINDEX_EN
                S_AIX_WR: begin
                    r_ram_we   <= 1'b0;
                    r_ram_oe   <= 1'b1;
                    r_ram_addr <= r_ram_wdata;
                    r_state    <= S_TGT_RD;
                end
`endif
                default: begin
                    r_ram_oe    <= 1'b0;
                    r_ram_we    <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_skip  = r_rsp_skip;
    assign ram_oe    = r_ram_oe;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master with a negedge-sampling 4096x12 memory model.
module tb_mem_master;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [11:0] cmd_addr;
    logic [11:0] cmd_wdata;
    logic        rsp_valid;
    logic [11:0] rsp_data;
    logic [11:0] rsp_addr;
    logic        rsp_skip;
    logic        ram_oe;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;

    mem_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_skip(rsp_skip),
        .ram_oe(ram_oe), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [11:0] mem [4096];

    // Memory samples controls at negedge; data outside oe cycles is junk.
    always @(negedge clk) begin
        if (ram_oe) ram_rdata <= mem[ram_addr];
        else        ram_rdata <= 12'o7070;
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    typedef struct {
        logic [11:0] data;
        logic [11:0] addr;
        logic        skip;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_rsp = 0;
    int   overlap = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o required %0o", name, act, exp);
        end
    endtask

    // Monitor: cycle counter, oe/we exclusivity and response comparison.
    always begin
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (ram_oe && ram_we) overlap++;
        if (rsp_valid) begin
            last_rsp = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_data"}, int'(rsp_data), int'(e.data));
                chk({e.name, "_addr"}, int'(rsp_addr), int'(e.addr));
                chk({e.name, "_skip"}, int'(rsp_skip), int'(e.skip));
                chk({e.name, "_lat"},  cyc - e.acc, e.lat);
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] op, input logic [11:0] a,
                         input logic [11:0] wd, input logic [11:0] ed, input logic [11:0] ea,
                         input logic es, input int el, input bit push, output int acc);
        exp_t e;
        int n = 0;
        acc = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk({name, "_ready_timeout"}, 0, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = wd;
        acc = cyc + 1;
        if (push) begin
            e.data = ed; e.addr = ea; e.skip = es; e.lat = el; e.acc = acc; e.name = name;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        // Scramble the command bus to show it is latched at acceptance.
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_addr  = ~a;
        cmd_wdata = ~wd;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, int'(n < 100), 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'o0200] = 12'o1234;
        mem[12'o0400] = 12'o7777;
        mem[12'o0401] = 12'o0005;
        mem[12'o0010] = 12'o0777;
        mem[12'o1000] = 12'o4321;
        mem[12'o0777] = 12'o2222;
        mem[12'o0020] = 12'o1500;
        mem[12'o1500] = 12'o0707;
        mem[12'o0017] = 12'o7777;
        mem[12'o0000] = 12'o3333;
        mem[12'o7777] = 12'o1111;
        mem[12'o0011] = 12'o0041;
        mem[12'o0402] = 12'o0123;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data",  int'(rsp_data), 0);
        chk("rst_rsp_addr",  int'(rsp_addr), 0);
        chk("rst_rsp_skip",  int'(rsp_skip), 0);
        chk("rst_ram_oe",    int'(ram_oe), 0);
        chk("rst_ram_we",    int'(ram_we), 0);
        chk("rst_ram_addr",  int'(ram_addr), 0);
        chk("rst_ram_wdata", int'(ram_wdata), 0);
        @(negedge clk);
        reset_n = 1'b1;

        issue("read200", 2'd0, 12'o0200, 12'o0000, 12'o1234, 12'o0200, 1'b0, 2, 1'b1, acc);
        wait_idle("read200");

        issue("write300", 2'd1, 12'o0300, 12'o5555, 12'o5555, 12'o0300, 1'b0, 2, 1'b1, acc);
        issue("read300", 2'd0, 12'o0300, 12'o0000, 12'o5555, 12'o0300, 1'b0, 2, 1'b1, acc);
        chk("b2b_accept_cycle", acc, last_rsp + 1);
        wait_idle("read300");

        issue("inc7777", 2'd2, 12'o0400, 12'o0000, 12'o0000, 12'o0400, 1'b1, 3, 1'b1, acc);
        wait_idle("inc7777");
        chk("inc7777_mem", int'(mem[12'o0400]), 12'o0000);

        issue("inc0005", 2'd2, 12'o0401, 12'o0000, 12'o0006, 12'o0401, 1'b0, 3, 1'b1, acc);
        wait_idle("inc0005");
        chk("inc0005_mem", int'(mem[12'o0401]), 12'o0006);

`ifdef MEM_AUTOINDEX_EN
        issue("ind10", 2'd3, 12'o0010, 12'o0000, 12'o4321, 12'o1000, 1'b0, 4, 1'b1, acc);
        wait_idle("ind10");
        chk("ind10_ptr_mem", int'(mem[12'o0010]), 12'o1000);
`else
        issue("ind10", 2'd3, 12'o0010, 12'o0000, 12'o2222, 12'o0777, 1'b0, 3, 1'b1, acc);
        wait_idle("ind10");
        chk("ind10_ptr_mem", int'(mem[12'o0010]), 12'o0777);
`endif

        issue("ind20", 2'd3, 12'o0020, 12'o0000, 12'o0707, 12'o1500, 1'b0, 3, 1'b1, acc);
        wait_idle("ind20");
        chk("ind20_ptr_mem", int'(mem[12'o0020]), 12'o1500);

`ifdef MEM_AUTOINDEX_EN
        issue("ind17wrap", 2'd3, 12'o0017, 12'o0000, 12'o3333, 12'o0000, 1'b0, 4, 1'b1, acc);
        wait_idle("ind17wrap");
        chk("ind17wrap_ptr_mem", int'(mem[12'o0017]), 12'o0000);
`else
        issue("ind17wrap", 2'd3, 12'o0017, 12'o0000, 12'o1111, 12'o7777, 1'b0, 3, 1'b1, acc);
        wait_idle("ind17wrap");
        chk("ind17wrap_ptr_mem", int'(mem[12'o0017]), 12'o7777);
`endif

        issue("inc11plain", 2'd2, 12'o0011, 12'o0000, 12'o0042, 12'o0011, 1'b0, 3, 1'b1, acc);
        wait_idle("inc11plain");
        chk("inc11plain_mem", int'(mem[12'o0011]), 12'o0042);

        // Reset during the INC_WR cycle, before the memory's negedge sample.
        issue("inc_rst", 2'd2, 12'o0402, 12'o0000, 12'o0000, 12'o0000, 1'b0, 0, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("inc_rst_we_before", int'(ram_we), 1);
        reset_n = 1'b0;
        #1;
        chk("inc_rst_we_drop", int'(ram_we), 0);
        chk("inc_rst_oe_drop", int'(ram_oe), 0);
        repeat (3) @(negedge clk);
        chk("inc_rst_mem", int'(mem[12'o0402]), 12'o0123);
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        chk("inc_rst_ready_after", int'(cmd_ready), 1);
        chk("inc_rst_no_rsp", int'(rsp_valid), 0);
        repeat (4) @(negedge clk);

        chk("oe_we_overlap", overlap, 0);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
